lane_arbiter: RTL and testbench
===============================

LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 Parameter DATA_W, default 35: packet word width (bits [34:32] header tag, [31:0] payload).
REQ-002 Parameter MAX_BEATS, default 16: maximum beats per grant before forced release; legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  4  per-lane request valid, index = lane 0..3.
REQ-006 req_data  input  4*DATA_W  per-lane packet word; lane n occupies bits [n*DATA_W +: DATA_W].
REQ-007 req_last  input  4  per-lane end-of-packet marker.
REQ-008 req_ready  output  4  per-lane accept; at most one bit high in any cycle.
REQ-009 out_valid  output  1  word valid toward the shared hardware subunit buffer.
REQ-010 out_data  output  DATA_W  forwarded word.
REQ-011 out_last  output  1  forwarded end-of-packet marker (1 on a forced-release beat).
REQ-012 out_ready  input  1  downstream accept.
REQ-013 grant_lane  output  2  index of the currently granted lane; valid only when busy = 1.
REQ-014 busy  output  1  1 in state GRANT.

Function
REQ-015 FSM states: IDLE, GRANT; no other states are reachable.
REQ-016 IDLE: if any req_valid bit = 1, latch the round-robin winner into grant_lane and move to GRANT on the next edge; otherwise remain in IDLE.
REQ-017 Round-robin winner: the first lane with req_valid = 1, searching upward from rr_ptr and wrapping 3 -> 0.
REQ-018 IDLE outputs: req_ready = 0, out_valid = 0, out_last = 0, out_data = 0.
REQ-019 GRANT outputs (combinational pass-through, zero latency):
  - out_valid = req_valid[g], out_data = req_data[g], out_last = req_last[g] OR forced;
  - req_ready[g] = out_ready; all other req_ready bits = 0.
REQ-020 Beat accepted = out_valid AND out_ready; beat_cnt increments on each accepted beat.
REQ-021 forced = 1 when beat_cnt = MAX_BEATS-1.
REQ-022 An accepted beat with out_last = 1 returns the FSM to IDLE, sets rr_ptr = (g+1) mod 4, and clears beat_cnt.
REQ-023 Grant-to-first-beat latency is 1 cycle; minimum gap between packets is 1 idle cycle.
REQ-024 A requester that deasserts req_valid mid-packet keeps its grant; the FSM stalls in GRANT.
REQ-025 Changes on non-granted lanes during GRANT have no effect on any output.
REQ-026 beat_cnt width is clog2(MAX_BEATS); beat_cnt never exceeds MAX_BEATS-1.

Reset
REQ-027 reset low forces state = IDLE, rr_ptr = 0, beat_cnt = 0, grant_lane = 0, and busy = 0 immediately, without waiting for clk.
REQ-028 Reset during GRANT abandons the packet; the first grant after reset release uses rr_ptr = 0.

Configuration
REQ-029 Macro LANE_ARBITER_STATS_EN:
  - Defined: adds output grant_count (4*16 bits), one 16-bit counter per lane. Each counter increments on every GRANT entry for its lane, saturates at 0xFFFF, and resets to 0.
  - Undefined: the port, the counters, and the related logic are absent.

Structure
REQ-030 Shared package lane_pkg holds:
  - the state enum (IDLE, GRANT);
  - the lane-count constant NUM_LANES = 4;
  - the header tag field positions;
  - the default DATA_W.
REQ-031 One sub-module, rr_pick: a combinational 4-bit request plus 2-bit pointer in, 2-bit winner and any-flag out.

Verification
REQ-032 Lanes 0 and 2 each request a 3-beat packet, out_ready = 1 -> lane 0 is granted first, its beats are forwarded, one idle cycle follows, then lane 2, then rr_ptr = 3.
REQ-033 All four lanes request continuously -> grant order is 0, 1, 2, 3, 0; no lane is granted twice before every other lane is granted once.
REQ-034 MAX_BEATS = 4, lane 1 sends 6 beats with no req_last -> out_last = 1 on beat 4, the FSM goes to IDLE, and lane 1 is re-granted only after the other pending lanes are served.
REQ-035 out_ready held 0 for 5 cycles mid-packet -> req_ready[g] = 0 throughout, beat_cnt is unchanged, and out_data holds its value.
REQ-036 reset asserted in GRANT after beat 2 -> busy = 0 and req_ready = 0 in the same cycle; after release, lane 0 wins if it is requesting.
REQ-037 With LANE_ARBITER_STATS_EN defined, 70000 grants to lane 3 -> grant_count lane 3 = 0xFFFF and the other lanes' counts are unchanged.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared definitions for the four-lane packet arbiter: FSM state type,
// lane count, packet header tag field positions and default word width.
package lane_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_LANES      = 4;
    localparam int LANE_IDX_W     = 2;

    // Packet word layout: [34:32] header tag, [31:0] payload.
    localparam int DEFAULT_DATA_W = 35;
    localparam int TAG_LSB        = 32;
    localparam int TAG_MSB        = 34;
    localparam int TAG_W          = TAG_MSB - TAG_LSB + 1;
    localparam int PAYLOAD_W      = 32;

    // Width of each per-lane grant statistics counter.
    localparam int STATS_W        = 16;

    // Lane that follows the given one in round-robin order (wraps 3 -> 0).
    function automatic logic [LANE_IDX_W-1:0] next_lane(input logic [LANE_IDX_W-1:0] lane);
        return lane + LANE_IDX_W'(1);
    endfunction

endpackage

// File: rtl/lane_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting lane found by searching
// upward from ptr and wrapping past the top lane. Purely combinational.
module rr_pick
    import lane_pkg::*;
(
    input  logic [NUM_LANES-1:0]  req,
    input  logic [LANE_IDX_W-1:0] ptr,
    output logic [LANE_IDX_W-1:0] winner,
    output logic                  any_req
);

    logic [LANE_IDX_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = ptr + LANE_IDX_W'(k);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_arbiter.sv
// lane_arbiter: four-lane round-robin packet arbiter feeding one shared
// downstream buffer. A lane holds its grant for a whole packet; a packet
// longer than MAX_BEATS is cut with a forced end-of-packet on beat MAX_BEATS.
//
// Optional build macro LANE_ARBITER_STATS_EN adds the grant_count output
// (one saturating 16-bit grant-entry counter per lane).
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no grant; outputs quiet; picks the round-robin winner if any lane
//       | requests and moves to GRANT on the next edge
// GRANT | granted lane's stream passes straight through to the output port;
//       | leaves on an accepted beat carrying out_last
module lane_arbiter
    import lane_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BEATS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES-1:0]        req_valid,
    input  logic [NUM_LANES*DATA_W-1:0] req_data,
    input  logic [NUM_LANES-1:0]        req_last,
    output logic [NUM_LANES-1:0]        req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [LANE_IDX_W-1:0]       grant_lane,
    output logic                        busy
`ifdef LANE_ARBITER_STATS_EN
    ,
    output logic [NUM_LANES*STATS_W-1:0] grant_count
`endif
);

    // Beat counter only needs to reach MAX_BEATS-1: that beat is always the last.
    localparam int                CNT_W     = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    arb_state_t             state_q;
    logic [LANE_IDX_W-1:0]  rr_ptr_q;
    logic [CNT_W-1:0]       beat_cnt_q;

    logic [LANE_IDX_W-1:0]  pick_lane;
    logic                   pick_any;
    logic                   forced;
    logic                   beat_acc;
    logic [DATA_W-1:0]      lane_word [NUM_LANES];

    rr_pick u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .winner  (pick_lane),
        .any_req (pick_any)
    );

    // Split the flat request bus into one word per lane.
    always_comb begin
        for (int n = 0; n < NUM_LANES; n++) begin
            lane_word[n] = req_data[n*DATA_W +: DATA_W];
        end
    end

    assign forced   = (beat_cnt_q == LAST_BEAT);
    assign beat_acc = out_valid & out_ready;

    // Zero-latency pass-through of the granted lane; everything quiet in IDLE.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == GRANT) begin
            out_valid             = req_valid[grant_lane];
            out_data              = lane_word[grant_lane];
            out_last              = req_last[grant_lane] | forced;
            req_ready[grant_lane] = out_ready;
        end
    end

    // Grant FSM with registered grant_lane/busy; a deasserted requester simply
    // stalls the grant, it never releases it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_lane <= '0;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q    <= GRANT;
                        grant_lane <= pick_lane;
                        busy       <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (beat_acc) begin
                        if (out_last) begin
                            state_q    <= IDLE;
                            busy       <= 1'b0;
                            rr_ptr_q   <= next_lane(grant_lane);
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LANE_ARBITER_STATS_EN
    logic [NUM_LANES-1:0][STATS_W-1:0] grant_cnt_q;

    // Count grant entries per lane, holding at all-ones once saturated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
        end else if (state_q == IDLE && pick_any && grant_cnt_q[pick_lane] != '1) begin
            grant_cnt_q[pick_lane] <= grant_cnt_q[pick_lane] + 1'b1;
        end
    end

    assign grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_lane_arbiter.sv
// Self-checking bench for lane_arbiter (built with MAX_BEATS = 4 so the
// forced-release path is reachable with short packets).
module tb_lane_arbiter;
    import lane_pkg::*;

    localparam int DW = 35;
    localparam int MB = 4;

    logic                clk;
    logic                reset;
    logic [3:0]          req_valid;
    logic [4*DW-1:0]     req_data;
    logic [3:0]          req_last;
    logic [3:0]          req_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic                out_ready;
    logic [1:0]          grant_lane;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    lane_arbiter #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .grant_lane (grant_lane),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic       exp_busy;
        logic [1:0] exp_g;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        int         exp_dlane;   // -1: out_data must be zero
        logic       exp_ol;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane_word(input int n);
        logic [2:0]  tag;
        logic [31:0] pay;
        tag = n[2:0];
        pay = 32'hC0DE_0000 + n[31:0];
        return {tag, pay};
    endfunction

    function automatic logic [4*DW-1:0] const_data();
        logic [4*DW-1:0] d;
        for (int n = 0; n < 4; n++) d[n*DW +: DW] = lane_word(n);
        return d;
    endfunction

    function automatic logic [4*DW-1:0] rand_data();
        logic [4*DW-1:0] d;
        logic [63:0]     r;
        for (int n = 0; n < 4; n++) begin
            r = {$urandom, $urandom};
            d[n*DW +: DW] = r[DW-1:0];
        end
        return d;
    endfunction

    function automatic void add_vec(input logic [3:0] v, input logic [3:0] l, input logic r,
                                    input logic b, input logic [1:0] g, input logic [3:0] rdy,
                                    input logic ov, input int dl, input logic ol);
        vec_t e;
        e.valid = v; e.last = l; e.ordy = r;
        e.exp_busy = b; e.exp_g = g; e.exp_rdy = rdy;
        e.exp_ov = ov; e.exp_dlane = dl; e.exp_ol = ol;
        vq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Two lanes with 3-beat packets, then a probe showing rr_ptr landed on 3.
    task automatic run_table();
        logic [DW-1:0] exp_d;
        vq.delete();
        add_vec(4'b0101, 4'b0000, 1, 0, 0, 4'b0000, 0, -1, 0);
        add_vec(4'b0101, 4'b0000, 1, 1, 0, 4'b0001, 1,  0, 0);
        add_vec(4'b0101, 4'b0000, 1, 1, 0, 4'b0001, 1,  0, 0);
        add_vec(4'b0101, 4'b0001, 1, 1, 0, 4'b0001, 1,  0, 1);
        add_vec(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 0, -1, 0);
        add_vec(4'b0100, 4'b0000, 1, 1, 2, 4'b0100, 1,  2, 0);
        add_vec(4'b0100, 4'b0000, 1, 1, 2, 4'b0100, 1,  2, 0);
        add_vec(4'b0100, 4'b0100, 1, 1, 2, 4'b0100, 1,  2, 1);
        add_vec(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, -1, 0);
        add_vec(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 0, -1, 0);
        add_vec(4'b1111, 4'b1000, 1, 1, 3, 4'b1000, 1,  3, 1);
        add_vec(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, -1, 0);
        req_data = const_data();
        for (int i = 0; i < vq.size(); i++) begin
            req_valid = vq[i].valid;
            req_last  = vq[i].last;
            out_ready = vq[i].ordy;
            @(negedge clk);
            exp_d = (vq[i].exp_dlane < 0) ? '0 : lane_word(vq[i].exp_dlane);
            chk("tbl_busy", busy, vq[i].exp_busy);
            if (vq[i].exp_busy) chk("tbl_grant", grant_lane, vq[i].exp_g);
            chk("tbl_req_ready", req_ready, vq[i].exp_rdy);
            chk("tbl_out_valid", out_valid, vq[i].exp_ov);
            chk("tbl_out_data", out_data, exp_d);
            chk("tbl_out_last", out_last, vq[i].exp_ol);
            tick();
        end
    endtask

    // All lanes request one-beat packets continuously: strict rotation.
    task automatic run_rotation();
        logic [1:0] q[$];
        logic       pb;
        int         exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        req_data  = const_data();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        pb = 1'b0;
        for (int c = 0; c < 40 && q.size() < 5; c++) begin
            @(negedge clk);
            if (busy && !pb) q.push_back(grant_lane);
            pb = busy;
            tick();
        end
        chk("rot_count", q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rot_order", (i < q.size()) ? {62'd0, q[i]} : 64'hDEAD, exp_order[i]);
    endtask

    // Lane 1 streams without req_last: cut on beat MB, then others served first.
    task automatic run_forced();
        logic [1:0] q[$];
        logic       pb;
        int         beats;
        int         exp_order[5];
        exp_order = '{1, 2, 3, 0, 1};
        do_reset();
        req_data  = const_data();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        out_ready = 1'b1;
        pb = 1'b0;
        beats = 0;
        for (int c = 0; c < 60 && q.size() < 5; c++) begin
            @(negedge clk);
            if (busy && !pb) q.push_back(grant_lane);
            if (busy && grant_lane == 2'd1 && q.size() == 1 && out_valid && out_ready) begin
                beats++;
                chk("forced_last", out_last, (beats == MB));
            end
            pb = busy;
            tick();
            req_valid = 4'b1111;
            req_last  = 4'b1101;
        end
        chk("forced_beats", beats, MB);
        for (int i = 0; i < 5; i++)
            chk("forced_order", (i < q.size()) ? {62'd0, q[i]} : 64'hDEAD, exp_order[i]);
    endtask

    // Backpressure and requester dropout mid-packet must not move beat count.
    task automatic run_stall();
        do_reset();
        req_data  = const_data();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_idle", busy, 0);
        tick();
        @(negedge clk);
        chk("stall_beat1", {busy, out_valid, out_last}, 3'b110);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b1111;
            req_data  = rand_data();
            req_data[0 +: DW] = lane_word(0);
            @(negedge clk);
            chk("stall_req_ready", req_ready, 4'b0000);
            chk("stall_out_data", out_data, lane_word(0));
            chk("stall_busy", {busy, grant_lane}, 3'b100);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            req_valid = 4'b1110;
            @(negedge clk);
            chk("drop_hold", {busy, grant_lane, out_valid}, 4'b1000);
            chk("drop_req_ready", req_ready, 4'b0001);
            tick();
        end
        req_valid = 4'b0001;
        req_data  = const_data();
        for (int b = 2; b <= MB; b++) begin
            @(negedge clk);
            chk("resume_valid", out_valid, 1);
            chk("resume_last", out_last, (b == MB));
            tick();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        chk("resume_idle", busy, 0);
        tick();
    endtask

    // Asynchronous reset in the middle of a grant.
    task automatic run_mid_reset();
        do_reset();
        req_data  = const_data();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("mr_beat1", {busy, grant_lane}, 3'b101);
        tick();
        @(negedge clk);
        chk("mr_beat2", {busy, grant_lane}, 3'b101);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_req_ready", req_ready, 4'b0000);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_grant", grant_lane, 0);
        req_valid = 4'b1111;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_post_idle", busy, 0);
        tick();
        @(negedge clk);
        chk("mr_first_grant", {busy, grant_lane}, 3'b100);
        tick();
    endtask

    // Random traffic against a packet-level reference model.
    task automatic run_random(input int cycles);
        bit         m_busy;
        int         m_g, m_ptr, m_beats, lane;
        logic       e_ov, e_ol;
        logic [3:0] e_rdy;
        logic [DW-1:0] e_d;
        do_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_beats = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int n = 0; n < 4; n++) begin
                req_valid[n] = ($urandom_range(0, 3) != 0);
                req_last[n]  = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            req_data  = rand_data();
            @(negedge clk);
            if (m_busy) begin
                e_ov  = req_valid[m_g];
                e_d   = req_data[m_g*DW +: DW];
                e_ol  = req_last[m_g] || (m_beats == MB - 1);
                e_rdy = 4'b0000;
                e_rdy[m_g] = out_ready;
            end else begin
                e_ov = 0; e_d = '0; e_ol = 0; e_rdy = 4'b0000;
            end
            chk("rnd_busy", busy, m_busy);
            if (m_busy) chk("rnd_grant", grant_lane, m_g);
            chk("rnd_req_ready", req_ready, e_rdy);
            chk("rnd_out_valid", out_valid, e_ov);
            chk("rnd_out_data", out_data, e_d);
            chk("rnd_out_last", out_last, e_ol);
            if (!m_busy) begin
                for (int k = 0; k < 4; k++) begin
                    lane = (m_ptr + k) % 4;
                    if (!m_busy && req_valid[lane]) begin
                        m_busy  = 1;
                        m_g     = lane;
                        m_beats = 0;
                    end
                end
            end else if (e_ov && out_ready) begin
                if (e_ol) begin
                    m_busy = 0;
                    m_ptr  = (m_g + 1) % 4;
                end else begin
                    m_beats++;
                end
            end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_lane, 0);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_out", {out_valid, out_last, out_data}, '0);
        tick();
        tick();
        reset = 1'b1;

        run_table();
        run_rotation();
        run_forced();
        run_stall();
        run_mid_reset();
        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
